// File: rtl/product_accumulator_pkg.sv
// Shared definitions for the product accumulator: parameter defaults and FSM state encoding.
// Imported by the interface and the top-level module.
package product_accumulator_pkg;

  localparam int PROD_W_DEF = 64;
  localparam int ACC_W_DEF  = 72;
  localparam int CNT_W_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } acc_state_e;

endpackage

// File: rtl/product_accumulator_if.sv
// Term input and batch-result output handshakes of the product accumulator.
// The master side feeds terms and consumes results; the slave side is the accumulator.
interface product_accumulator_if
  import product_accumulator_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
);

  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] in_product;
  logic              in_last;

  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic [CNT_W-1:0]  out_count;
  logic              out_overflow;
  logic              out_trunc;

  modport master (
    output in_valid, in_product, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_overflow, out_trunc
  );

  modport slave (
    input  in_valid, in_product, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_overflow, out_trunc
  );

endinterface

// File: rtl/product_accumulator_acc_adder.sv
// Unsigned W-bit adder with carry-out; the carry feeds the per-batch overflow flag.
module acc_adder #(
  parameter int W = 72
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         carry
);

  assign {carry, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/product_accumulator.sv
// Sums batches of unsigned products into a wide accumulator and presents each batch result
// on a valid/ready output; supports zero-bubble retire-and-restart while a result is held.
module product_accumulator
  import product_accumulator_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  product_accumulator_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  acc_state_e        state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;

  logic              out_valid_q, out_valid_d;
  logic [ACC_W-1:0]  out_sum_q, out_sum_d;
  logic [CNT_W-1:0]  out_count_q, out_count_d;
  logic              out_ovf_q, out_ovf_d;
  logic              out_trunc_q, out_trunc_d;

  logic              in_ready;
  logic              accept;
  logic              retire;
  logic              continuing;
  logic [ACC_W-1:0]  add_base;
  logic [ACC_W-1:0]  prod_ext;
  logic [ACC_W-1:0]  add_sum;
  logic              add_carry;
  logic [CNT_W-1:0]  new_cnt;
  logic              new_ovf;
  logic              closing;

  assign in_ready = (state_q != HOLD) | bus.out_ready;
  assign accept   = bus.in_valid & in_ready;
  assign retire   = (state_q == HOLD) & bus.out_ready;

  // Only an open batch carries its running sum forward; IDLE and HOLD start from zero.
  assign continuing = (state_q == ACCUM);
  assign add_base   = continuing ? acc_q : '0;
  assign prod_ext   = ACC_W'(bus.in_product);
  assign new_cnt    = (continuing ? cnt_q : '0) + 1'b1;
  assign new_ovf    = (continuing & ovf_q) | add_carry;
  assign closing    = bus.in_last | (new_cnt == CNT_MAX);

  acc_adder #(
    .W (ACC_W)
  ) u_acc_adder (
    .a     (add_base),
    .b     (prod_ext),
    .sum   (add_sum),
    .carry (add_carry)
  );

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;
    out_trunc_d = out_trunc_q;

    if (retire) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
    end

    // in_product/in_last are consulted only under accept so undriven inputs never reach state.
    if (accept) begin
      if (closing) begin
        state_d     = HOLD;
        acc_d       = '0;
        cnt_d       = '0;
        ovf_d       = 1'b0;
        out_valid_d = 1'b1;
        out_sum_d   = add_sum;
        out_count_d = new_cnt;
        out_ovf_d   = new_ovf;
        out_trunc_d = ~bus.in_last;
      end else begin
        state_d = ACCUM;
        acc_d   = add_sum;
        cnt_d   = new_cnt;
        ovf_d   = new_ovf;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
      out_trunc_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
      out_trunc_q <= out_trunc_d;
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_sum      = out_sum_q;
  assign bus.out_count    = out_count_q;
  assign bus.out_overflow = out_ovf_q;
  assign bus.out_trunc    = out_trunc_q;

endmodule
